// File: rtl/iot_pkg.sv
// Shared definitions for the device event source.
// Contents: pending-state encoding, default device count, clog2 helper.
package iot_pkg;

  localparam int unsigned N_DEV_DEF = 4;

  // Per-device pending event state
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_ON   = 2'b01;
  localparam logic [1:0] ST_OFF  = 2'b10;

  // Ceiling log2 used to size device indices
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iot_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req         - request vector, one bit per device
//   ptr         - index of the last winner; search starts at ptr+1
//   hold        - suppresses all grants
//   grant_c     - one-hot grant
//   grant_idx_c - index of the granted device (0 when none)
//   any_grant_c - 1 when a grant was issued
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            hold,
  output logic [N-1:0]    grant_c,
  output logic [ID_W-1:0] grant_idx_c,
  output logic            any_grant_c
);

  // Walk devices ptr+1, ptr+2, ... (mod N); first requester wins
  always_comb begin
    logic [ID_W-1:0] idx;
    int unsigned     pos;
    grant_c     = '0;
    grant_idx_c = '0;
    any_grant_c = 1'b0;
    idx         = '0;
    pos         = 0;
    if (!hold) begin
      for (int unsigned k = 1; k <= N; k++) begin
        pos = (32'(ptr) + k) % N;
        idx = ID_W'(pos);
        if (!any_grant_c && req[idx]) begin
          any_grant_c  = 1'b1;
          grant_c[idx] = 1'b1;
          grant_idx_c  = idx;
        end
      end
    end
  end

endmodule

// File: rtl/iot_event_source.sv
// Converts per-device link-status edges into single-cycle connect/disconnect
// events, one per cycle, round-robin across devices. Opposing edges that are
// still pending cancel each other so a downstream up/down counter converges.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   dev_status   - per-device level, 1 = connected
//   hold         - suppress emission; edges keep being recorded
//   change       - 1 for one cycle per emitted event
//   on_off       - 1 = connect, 0 = disconnect (valid with change)
//   dev_id       - device index of the event (valid with change)
//   pending_any  - some device has an unserviced event
module iot_event_source
  import iot_pkg::*;
#(
  parameter int unsigned N_DEV = N_DEV_DEF,
  parameter int unsigned ID_W  = clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             hold,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             pending_any
);

  logic [N_DEV-1:0] prev_status_q, prev_status_d;
  logic [1:0]       state_q [N_DEV];
  logic [1:0]       state_d [N_DEV];
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic [ID_W-1:0]  dev_id_q, dev_id_d;
  logic             pending_any_q, pending_any_d;

  logic [N_DEV-1:0] rise_c, fall_c, req_c, grant_c;
  logic [ID_W-1:0]  grant_idx_c;
  logic             any_grant_c;

  // Edge detection and request generation
  always_comb begin
    rise_c = dev_status & ~prev_status_q;
    fall_c = ~dev_status & prev_status_q;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      req_c[i] = (state_q[i] != ST_NONE) & ~hold;
    end
  end

  rr_arbiter #(
    .N    (N_DEV),
    .ID_W (ID_W)
  ) u_arb (
    .req         (req_c),
    .ptr         (ptr_q),
    .hold        (hold),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_grant_c (any_grant_c)
  );

  // Pending FSMs: grant clears first, then the new edge is netted in
  always_comb begin
    logic [1:0] s;
    s             = ST_NONE;
    pending_any_d = 1'b0;
    prev_status_d = dev_status;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      s = grant_c[i] ? ST_NONE : state_q[i];
      if (rise_c[i]) begin
        case (s)
          ST_NONE: s = ST_ON;
          ST_OFF:  s = ST_NONE;
          default: s = s;
        endcase
      end else if (fall_c[i]) begin
        case (s)
          ST_NONE: s = ST_OFF;
          ST_ON:   s = ST_NONE;
          default: s = s;
        endcase
      end
      state_d[i]    = s;
      pending_any_d = pending_any_d | (s != ST_NONE);
    end
  end

  // Output and pointer next-state; on_off/dev_id hold when idle
  always_comb begin
    change_d = any_grant_c;
    on_off_d = on_off_q;
    dev_id_d = dev_id_q;
    ptr_d    = ptr_q;
    if (any_grant_c) begin
      on_off_d = (state_q[grant_idx_c] == ST_ON);
      dev_id_d = grant_idx_c;
      ptr_d    = grant_idx_c;
    end
  end

  // Reset leaves ptr at the last device so device 0 is searched first
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_status_q <= '0;
      ptr_q         <= ID_W'(N_DEV - 1);
      change_q      <= 1'b0;
      on_off_q      <= 1'b0;
      dev_id_q      <= '0;
      pending_any_q <= 1'b0;
      for (int unsigned i = 0; i < N_DEV; i++) begin
        state_q[i] <= ST_NONE;
      end
    end else begin
      prev_status_q <= prev_status_d;
      ptr_q         <= ptr_d;
      change_q      <= change_d;
      on_off_q      <= on_off_d;
      dev_id_q      <= dev_id_d;
      pending_any_q <= pending_any_d;
      for (int unsigned i = 0; i < N_DEV; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign change      = change_q;
  assign on_off      = on_off_q;
  assign dev_id      = dev_id_q;
  assign pending_any = pending_any_q;

  // Status alternates, so a repeated edge direction while pending is illegal
  for (genvar g = 0; g < int'(N_DEV); g++) begin : g_edge_chk
    a_no_double_edge : assert property (@(posedge clk) disable iff (rst)
      !((rise_c[g] && state_q[g] == ST_ON) || (fall_c[g] && state_q[g] == ST_OFF)));
  end

endmodule

// File: tb/tb_iot_event_source.sv
// Bench for iot_event_source: directed scenarios plus random toggling, all
// checked against a net-pending-count reference model.
module tb_iot_event_source;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         hold;
  logic [N-1:0] dev_status;
  logic         change;
  logic         on_off;
  logic [W-1:0] dev_id;
  logic         pending_any;

  iot_event_source #(.N_DEV(N), .ID_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dev_status  (dev_status),
    .hold        (hold),
    .change      (change),
    .on_off      (on_off),
    .dev_id      (dev_id),
    .pending_any (pending_any)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: m_pend[i] = status level change not yet reported (-1/0/+1)
  int m_pend [N];
  int m_prev [N];
  int m_ptr;
  int e_change, e_on_off, e_dev, e_pend;
  int cnt;
  int rst_seen;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int w;
    int d;
    w = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
      end
      m_ptr    = N - 1;
      e_change = 0;
      e_on_off = 0;
      e_dev    = 0;
      e_pend   = 0;
    end else begin
      if (!hold) begin
        for (int k = 1; k <= N; k++) begin
          d = (m_ptr + k) % N;
          if (w < 0 && m_pend[d] != 0) w = d;
        end
      end
      if (w >= 0) begin
        e_change  = 1;
        e_on_off  = (m_pend[w] > 0) ? 1 : 0;
        e_dev     = w;
        m_pend[w] = 0;
        m_ptr     = w;
      end else begin
        e_change = 0;
      end
      e_pend = 0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = m_pend[i] + int'(dev_status[i]) - m_prev[i];
        m_prev[i] = int'(dev_status[i]);
        if (m_pend[i] != 0) e_pend = 1;
      end
    end
  endtask

  // One clock: model updates on the edge, DUT is compared on the falling edge
  task automatic step();
    int pc;
    @(posedge clk);
    rst_seen = int'(rst);
    model_edge();
    @(negedge clk);
    chk("change", int'(change), e_change);
    chk("on_off", int'(on_off), e_on_off);
    chk("dev_id", int'(dev_id), e_dev);
    chk("pending_any", int'(pending_any), e_pend);
    if (rst_seen != 0) cnt = 0;
    else if (change) cnt = on_off ? cnt + 1 : cnt - 1;
    if (!pending_any) begin
      pc = 0;
      for (int i = 0; i < N; i++) pc += m_prev[i];
      chk("conserve", cnt, pc);
    end
  endtask

  initial begin
    rst        = 1'b1;
    hold       = 1'b0;
    dev_status = '0;
    cnt        = 0;
    step();

    // Reset release with devices 0 and 2 already connected
    dev_status = 4'b0101;
    step();
    chk("rst_change", int'(change), 0);
    chk("rst_dev_id", int'(dev_id), 0);
    chk("rst_pending", int'(pending_any), 0);
    rst = 1'b0;
    step();
    chk("rel_latency", int'(change), 0);
    step();
    chk("rel_ev0_change", int'(change), 1);
    chk("rel_ev0_dev", int'(dev_id), 0);
    chk("rel_ev0_on", int'(on_off), 1);
    step();
    chk("rel_ev1_change", int'(change), 1);
    chk("rel_ev1_dev", int'(dev_id), 2);
    step();
    chk("rel_idle_change", int'(change), 0);
    chk("rel_idle_pending", int'(pending_any), 0);

    // Single connect then disconnect on device 1
    dev_status[1] = 1'b1;
    step();
    chk("d1_latency", int'(change), 0);
    step();
    chk("d1_on_change", int'(change), 1);
    chk("d1_on_dev", int'(dev_id), 1);
    chk("d1_on_val", int'(on_off), 1);
    step();
    chk("d1_single_cycle", int'(change), 0);
    dev_status[1] = 1'b0;
    step();
    step();
    chk("d1_off_change", int'(change), 1);
    chk("d1_off_dev", int'(dev_id), 1);
    chk("d1_off_val", int'(on_off), 0);

    // Held rise then fall on device 3 cancels out
    hold = 1'b1;
    dev_status[3] = 1'b1;
    step();
    chk("hold_pending", int'(pending_any), 1);
    step();
    chk("hold_no_event", int'(change), 0);
    dev_status[3] = 1'b0;
    step();
    chk("hold_cancel", int'(pending_any), 0);
    step();
    hold = 1'b0;
    step();
    step();
    chk("hold_after_change", int'(change), 0);
    chk("hold_after_pending", int'(pending_any), 0);

    // All devices rise together from a fresh reset
    rst = 1'b1;
    dev_status = '0;
    step();
    rst = 1'b0;
    step();
    dev_status = 4'hF;
    step();
    for (int i = 0; i < N; i++) begin
      step();
      chk("all_change", int'(change), 1);
      chk("all_dev", int'(dev_id), i);
      chk("all_on", int'(on_off), 1);
    end
    step();
    chk("all_done", int'(change), 0);

    // Device 0 granted in the same cycle it falls
    rst = 1'b1;
    dev_status = '0;
    step();
    rst = 1'b0;
    step();
    dev_status = 4'b0001;
    step();
    dev_status = 4'b0000;
    step();
    chk("race_on_change", int'(change), 1);
    chk("race_on_val", int'(on_off), 1);
    chk("race_on_dev", int'(dev_id), 0);
    step();
    chk("race_off_change", int'(change), 1);
    chk("race_off_val", int'(on_off), 0);
    chk("race_off_dev", int'(dev_id), 0);
    step();
    chk("race_net", cnt, 0);
    chk("race_pending", int'(pending_any), 0);

    // Random toggling with occasional hold and mid-burst reset
    for (int c = 0; c < 10000; c++) begin
      rst  = ($urandom_range(0, 499) == 0);
      hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) dev_status[i] = ~dev_status[i];
      end
      step();
    end

    // Drain and confirm convergence
    rst  = 1'b0;
    hold = 1'b0;
    for (int c = 0; c < 2 * N + 2; c++) step();
    chk("final_pending", int'(pending_any), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
